// File: rtl/iomem_timer.sv
// iomem_timer: 32-bit timer/compare on the iomem bus; IOMEM_TIMER_PRESCALER_EN adds the PRESCALE divider at 0x10.
// Latency: ready one cycle after select, one-cycle pulse; no backpressure, the master holds valid until ready.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    logic        enable, irq_en, auto_reload, oneshot, pending;
    logic [31:0] count, compare;
    logic [31:0] rd_mux, prescale_rd;
    logic [5:0]  word;
    logic        sel, acc, wr, tick, match;
    logic        wr_ctrl, wr_count, wr_compare, wr_status;
    logic        unused_addr_bits;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    assign word             = iomem_addr[7:2];
    assign unused_addr_bits = ^iomem_addr[1:0];
    assign sel        = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    // acc marks the single edge where the access completes and registers update
    assign acc        = sel && !iomem_ready;
    assign wr         = acc && (iomem_wstrb != 4'b0000);
    assign wr_ctrl    = wr && (word == 6'h00);
    assign wr_count   = wr && (word == 6'h01);
    assign wr_compare = wr && (word == 6'h02);
    assign wr_status  = wr && (word == 6'h03);
    assign match      = tick && (count == compare);
    assign irq        = pending & irq_en;

`ifdef IOMEM_TIMER_PRESCALER_EN
    logic [15:0] prescale, pcnt;
    logic        wr_prescale;

    assign wr_prescale = wr && (word == 6'h04);
    assign tick        = enable && (pcnt == prescale);
    assign prescale_rd = {16'b0, prescale};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            if (wr_prescale && iomem_wstrb[0]) prescale[7:0]  <= iomem_wdata[7:0];
            if (wr_prescale && iomem_wstrb[1]) prescale[15:8] <= iomem_wdata[15:8];
            if (wr_prescale || !enable || pcnt == prescale)
                pcnt <= '0;
            else
                pcnt <= pcnt + 16'd1;
        end
    end
`else
    assign tick        = enable;
    assign prescale_rd = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (word)
            6'h00:   rd_mux = {28'b0, oneshot, auto_reload, irq_en, enable};
            6'h01:   rd_mux = count;
            6'h02:   rd_mux = compare;
            6'h03:   rd_mux = {31'b0, pending};
            6'h04:   rd_mux = prescale_rd;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            auto_reload <= 1'b0;
            oneshot     <= 1'b0;
            pending     <= 1'b0;
            count       <= '0;
            compare     <= '0;
        end else begin
            iomem_ready <= acc;
            iomem_rdata <= acc ? rd_mux : 32'b0;

            // Bus write to CTRL outranks the oneshot self-disable
            if (wr_ctrl && iomem_wstrb[0]) begin
                enable      <= iomem_wdata[0];
                irq_en      <= iomem_wdata[1];
                auto_reload <= iomem_wdata[2];
                oneshot     <= iomem_wdata[3];
            end else if (match && oneshot) begin
                enable <= 1'b0;
            end

            if (wr_count)
                count <= merge(count, iomem_wdata, iomem_wstrb);
            else if (tick)
                count <= (match && auto_reload) ? 32'b0 : count + 32'd1;

            if (wr_compare)
                compare <= merge(compare, iomem_wdata, iomem_wstrb);

            // A match on the same edge wins over a W1C
            if (match)
                pending <= 1'b1;
            else if (wr_status && iomem_wstrb[0] && iomem_wdata[0])
                pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iomem_timer.sv
// Scoreboarded bench for iomem_timer: stimulus pushes expected read data, a negedge monitor pops and compares on ready.
module tb_iomem_timer;

    localparam logic [31:0] B = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic [3:0]  iomem_wstrb = 4'b0;
    logic [31:0] iomem_addr = 32'b0;
    logic [31:0] iomem_wdata = 32'b0;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic prev_ready = 1'b0;

    iomem_timer #(.BASE_ADDR(B)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .iomem_valid(iomem_valid),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_ready(iomem_ready),
        .iomem_rdata(iomem_rdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Monitor
    always @(negedge clk) begin
        if (iomem_ready) begin
            checks++;
            if (prev_ready) begin
                errors++;
                $display("FAIL ready_width: ready high for 2 cycles, required 1");
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: ready=1 with no access outstanding, required 0");
            end else begin
                cur = exp_q.pop_front();
                if (cur.chk) begin
                    checks++;
                    if (iomem_rdata !== cur.dat) begin
                        errors++;
                        $display("FAIL rdata addr=%h: got %h, required %h", iomem_addr, iomem_rdata, cur.dat);
                    end
                end
            end
        end else begin
            checks++;
            if (iomem_rdata !== 32'b0) begin
                errors++;
                $display("FAIL rdata_idle: got %h while ready=0, required 0", iomem_rdata);
            end
        end
        prev_ready = iomem_ready;
    end

    task automatic access(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                          input logic chk, input logic [31:0] exp_dat);
        int n;
        exp_q.push_back(exp_t'{chk: chk, dat: exp_dat});
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = be;
        iomem_wdata = wd;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!iomem_ready && n < 20);
        checks++;
        if (!iomem_ready) begin
            errors++;
            $display("FAIL ready_timeout addr=%h: got no ready in 20 cycles, required ready", addr);
            void'(exp_q.pop_back());
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        access(addr, be, wd, 1'b0, 32'b0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_dat);
        access(addr, 4'b0, 32'b0, 1'b1, exp_dat);
    endtask

    task automatic check_irq(input logic exp_v, input string name);
        checks++;
        if (irq !== exp_v) begin
            errors++;
            $display("FAIL irq_%s: got %b, required %b", name, irq, exp_v);
        end
    endtask

    task automatic no_ready(input logic [31:0] addr);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = 4'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (iomem_ready !== 1'b0) begin
                errors++;
                $display("FAIL out_of_window addr=%h: got ready=%b, required 0", addr, iomem_ready);
            end
        end
        iomem_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (iomem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 0", iomem_ready);
        end
        check_irq(1'b0, "reset");
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and register map
        do_reset();
        rd(B + 32'h00, 32'h0);
        rd(B + 32'h04, 32'h0);
        rd(B + 32'h08, 32'h0);
        rd(B + 32'h0C, 32'h0);
        rd(B + 32'h10, 32'h0);
        check_irq(1'b0, "after_reset_reads");
        wr(B + 32'h08, 4'b0101, 32'hAABB_CCDD);
        rd(B + 32'h08, 32'h00BB_00DD);
        rd(B + 32'h0B, 32'h00BB_00DD);
        wr(B + 32'h00, 4'hF, 32'hFFFF_FF02);
        rd(B + 32'h00, 32'h0000_0002);
        wr(B + 32'h00, 4'hF, 32'h0);
        wr(B + 32'h10, 4'hF, 32'hFFFF_0003);
`ifdef IOMEM_TIMER_PRESCALER_EN
        rd(B + 32'h10, 32'h0000_0003);
`else
        rd(B + 32'h10, 32'h0);
`endif
        wr(B + 32'h40, 4'hF, 32'h1234_5678);
        rd(B + 32'h40, 32'h0);
        no_ready(32'h0400_0000);

        // Auto-reload: COMPARE=3, PRESCALE=0, CTRL=0x7 written at edge C
        do_reset();
        wr(B + 32'h08, 4'hF, 32'd3);
        wr(B + 32'h10, 4'hF, 32'd0);
        wr(B + 32'h00, 4'hF, 32'h7);
        rd(B + 32'h04, 32'd1);
        check_irq(1'b0, "before_match");
        rd(B + 32'h04, 32'd3);
        check_irq(1'b1, "on_wrap");
        wr(B + 32'h0C, 4'hF, 32'h1);
        check_irq(1'b0, "after_w1c");
        wr(B + 32'h0C, 4'hF, 32'h1);
        check_irq(1'b1, "w1c_vs_match");
        rd(B + 32'h0C, 32'h1);

        // Oneshot: COMPARE=1, PRESCALE=2, CTRL=0x9
        do_reset();
        wr(B + 32'h08, 4'hF, 32'd1);
        wr(B + 32'h10, 4'hF, 32'd2);
        wr(B + 32'h00, 4'hF, 32'h9);
`ifdef IOMEM_TIMER_PRESCALER_EN
        rd(B + 32'h04, 32'd0);
        rd(B + 32'h04, 32'd1);
        rd(B + 32'h04, 32'd1);
        rd(B + 32'h04, 32'd2);
`else
        rd(B + 32'h04, 32'd1);
        rd(B + 32'h04, 32'd2);
        rd(B + 32'h04, 32'd2);
        rd(B + 32'h04, 32'd2);
`endif
        rd(B + 32'h00, 32'h8);
        rd(B + 32'h0C, 32'h1);
        rd(B + 32'h04, 32'd2);
        check_irq(1'b0, "irq_en_off");
`ifdef IOMEM_TIMER_PRESCALER_EN
        rd(B + 32'h10, 32'd2);
`else
        rd(B + 32'h10, 32'd0);
`endif

        // Wrap without flag, then a COUNT write racing a tick
        do_reset();
        wr(B + 32'h04, 4'hF, 32'hFFFF_FFFF);
        wr(B + 32'h08, 4'hF, 32'd5);
        wr(B + 32'h00, 4'hF, 32'h1);
        rd(B + 32'h04, 32'd0);
        rd(B + 32'h0C, 32'h0);
        wr(B + 32'h04, 4'hF, 32'd100);
        rd(B + 32'h04, 32'd101);

        // Reset during a pending write discards it
        do_reset();
        iomem_valid = 1'b1;
        iomem_addr  = B + 32'h08;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h55;
        resetn      = 1'b0;
        @(posedge clk);
        #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        resetn      = 1'b1;
        rd(B + 32'h08, 32'h0);

        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
